// File: rtl/classifier_stream_sequencer.sv
// Frame sequencer: streams features and per-class weights to the MAC/argmax, then latches the winner.
// Addresses lead the MAC strobes by one cycle; start is ignored while busy, there is no backpressure.
module classifier_stream_sequencer #(
   parameter int N_FEAT     = 4,
   parameter int N_CLASS    = 3,
   parameter int CLASS_BITS = 3,
   parameter int FA_BITS    = 2,
   parameter int WA_BITS    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [FA_BITS-1:0]    feat_addr,
   input  logic [3:0]            feat_rdata,
   output logic [WA_BITS-1:0]    w_addr,
   input  logic [7:0]            w_rdata,
   output logic [3:0]            x_int4,
   output logic [7:0]            w_int8,
   output logic                  new_feat,
   output logic                  new_class,
   output logic [CLASS_BITS-1:0] class_id,
   output logic                  frame_start,
   input  logic [CLASS_BITS-1:0] max_class,
   output logic [CLASS_BITS-1:0] result_class
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_GAP   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;

   logic [2:0]            state;
   logic [CLASS_BITS-1:0] cls;
   logic                  last_feat;
   logic                  last_class;

   assign last_feat  = (feat_addr == FA_BITS'(N_FEAT - 1));
   assign last_class = (cls == CLASS_BITS'(N_CLASS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cls          <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         feat_addr    <= '0;
         w_addr       <= '0;
         new_feat     <= 1'b0;
         new_class    <= 1'b0;
         frame_start  <= 1'b0;
         class_id     <= '0;
         result_class <= '0;
      end else begin
         // Output stage trails the address stage by exactly one cycle.
         done        <= 1'b0;
         new_feat    <= (state == S_ISSUE);
         new_class   <= (state == S_GAP);
         frame_start <= (state == S_ISSUE) && (cls == '0) && (feat_addr == '0);
         if (state == S_ISSUE || state == S_GAP) begin
            class_id <= cls;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_ISSUE;
                  busy      <= 1'b1;
                  cls       <= '0;
                  feat_addr <= '0;
                  w_addr    <= '0;
               end
            end
            S_ISSUE: begin
               if (last_feat) begin
                  state <= S_GAP;
               end else begin
                  feat_addr <= feat_addr + FA_BITS'(1);
                  w_addr    <= w_addr + WA_BITS'(1);
               end
            end
            S_GAP: begin
               if (last_class) begin
                  state <= S_DRAIN;
               end else begin
                  // Weight rows are contiguous, so the next class starts one past the last address.
                  state     <= S_ISSUE;
                  cls       <= cls + CLASS_BITS'(1);
                  feat_addr <= '0;
                  w_addr    <= w_addr + WA_BITS'(1);
               end
            end
            S_DRAIN: begin
               state <= S_FIN;
            end
            S_FIN: begin
               state        <= S_IDLE;
               result_class <= max_class;
               done         <= 1'b1;
               busy         <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign x_int4 = new_feat ? feat_rdata : 4'd0;
   assign w_int8 = new_feat ? w_rdata    : 8'd0;

endmodule

// File: tb/tb_classifier_stream_sequencer.sv
// Bench for classifier_stream_sequencer: behavioural memories and argmax, expected stream held in a queue.
`timescale 1ns/1ps
module tb_classifier_stream_sequencer;
   localparam int NF = 4;
   localparam int NC = 3;

   typedef struct packed {
      logic       nf;
      logic       nc;
      logic       fs;
      logic [2:0] cid;
      logic [3:0] x;
      logic [7:0] w;
   } item_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, new_feat, new_class, frame_start;
   logic [1:0] feat_addr;
   logic [3:0] w_addr;
   logic [3:0] feat_rdata = '0;
   logic [3:0] x_int4;
   logic [7:0] w_rdata = '0;
   logic [7:0] w_int8;
   logic [2:0] class_id, result_class;
   logic [2:0] max_class = '0;

   logic       start1 = 1'b0;
   logic       busy1, done1, new_feat1, new_class1, frame_start1;
   logic [0:0] feat_addr1, w_addr1;
   logic [3:0] feat_rdata1 = '0;
   logic [3:0] x_int41;
   logic [7:0] w_rdata1 = '0;
   logic [7:0] w_int81;
   logic [2:0] class_id1, result_class1;
   logic [2:0] max_class1 = 3'd6;

   always #5 clk = ~clk;

   classifier_stream_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .feat_addr(feat_addr), .feat_rdata(feat_rdata), .w_addr(w_addr), .w_rdata(w_rdata),
      .x_int4(x_int4), .w_int8(w_int8), .new_feat(new_feat), .new_class(new_class),
      .class_id(class_id), .frame_start(frame_start), .max_class(max_class),
      .result_class(result_class)
   );

   classifier_stream_sequencer #(
      .N_FEAT(1), .N_CLASS(1), .CLASS_BITS(3), .FA_BITS(1), .WA_BITS(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
      .feat_addr(feat_addr1), .feat_rdata(feat_rdata1), .w_addr(w_addr1), .w_rdata(w_rdata1),
      .x_int4(x_int41), .w_int8(w_int81), .new_feat(new_feat1), .new_class(new_class1),
      .class_id(class_id1), .frame_start(frame_start1), .max_class(max_class1),
      .result_class(result_class1)
   );

   // Synchronous-read memories, one cycle of latency.
   logic [3:0] feat_mem [4];
   logic [7:0] w_mem [16];
   int gf [4]  = '{5, 3, 1, 0};
   int gw [12] = '{36, 69, -127, -39, 21, -13, -5, -46, -68, -48, 88, 81};

   always @(posedge clk) begin
      feat_rdata  <= feat_mem[feat_addr];
      w_rdata     <= w_mem[w_addr];
      feat_rdata1 <= (feat_addr1 == 1'b0) ? 4'hD : 4'h0;
      w_rdata1    <= (w_addr1 == 1'b0) ? 8'd9 : 8'h0;
   end

   // Behavioural MAC + argmax; first class wins ties.
   int acc = 0;
   int best = 0;
   bit best_vld = 1'b0;
   int score_log[$];

   always @(posedge clk) begin
      if (new_feat) acc <= (frame_start ? 0 : acc) + int'($signed(x_int4)) * int'($signed(w_int8));
      if (frame_start) best_vld <= 1'b0;
      if (new_class) begin
         score_log.push_back(acc);
         if (!best_vld || acc > best) begin
            best      <= acc;
            best_vld  <= 1'b1;
            max_class <= class_id;
         end
         acc <= 0;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int    checks = 0;
   int    errors = 0;
   item_t exp_q[$];
   item_t obs_q[$];
   int    fs_cyc[$];
   int    done_cyc[$];
   int    addr_log[$];
   int    last_nc_cyc = 0;
   int    both_cnt = 0;
   bit    busy_at_done = 1'b0;
   logic [3:0] prev_w = '0;

   task automatic load_mem(input bit swap);
      int src;
      for (int f = 0; f < NF; f++) feat_mem[f] = 4'(gf[f]);
      for (int i = 0; i < 16; i++) w_mem[i] = 8'h0;
      for (int i = 0; i < NC * NF; i++) begin
         src = swap ? ((i < 4) ? i + 4 : (i < 8) ? i - 4 : i) : i;
         w_mem[i] = 8'(gw[src]);
      end
   endtask

   task automatic push_frame();
      item_t it;
      for (int c = 0; c < NC; c++) begin
         for (int f = 0; f < NF; f++) begin
            it.nf = 1'b1; it.nc = 1'b0; it.fs = (c == 0 && f == 0);
            it.cid = 3'(c); it.x = feat_mem[f]; it.w = w_mem[c * NF + f];
            exp_q.push_back(it);
         end
         it.nf = 1'b0; it.nc = 1'b1; it.fs = 1'b0; it.cid = 3'(c); it.x = 4'h0; it.w = 8'h0;
         exp_q.push_back(it);
      end
   endtask

   task automatic clear_logs();
      obs_q.delete(); fs_cyc.delete(); done_cyc.delete(); addr_log.delete();
      busy_at_done = 1'b0;
   endtask

   // Samples the DUT at falling edges; stops after ndone done pulses (0 = run ncyc cycles).
   task automatic watch(input int ncyc, input int ndone);
      int    seen = 0;
      item_t o;
      for (int k = 0; k < ncyc && (ndone == 0 || seen < ndone); k++) begin
         @(negedge clk);
         if (new_feat || new_class) begin
            o.nf = new_feat; o.nc = new_class; o.fs = frame_start;
            o.cid = class_id; o.x = x_int4; o.w = w_int8;
            obs_q.push_back(o);
         end
         if (new_feat) addr_log.push_back(int'(prev_w));
         prev_w = w_addr;
         if (frame_start) fs_cyc.push_back(cyc);
         if (new_class) last_nc_cyc = cyc;
         if (done) begin
            done_cyc.push_back(cyc);
            seen++;
            if (busy) busy_at_done = 1'b1;
         end
         if ((new_feat && new_class) || (new_feat1 && new_class1)) both_cnt++;
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      start = 1'b1; start1 = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, new_feat, new_class, frame_start, feat_addr, w_addr, class_id,
           result_class, x_int4, w_int8} !== '0) begin
         errors++;
         $display("FAIL reset_outputs busy=%b done=%b nf=%b nc=%b fa=%h wa=%h cid=%h res=%h x=%h w=%h want all 0",
                  busy, done, new_feat, new_class, feat_addr, w_addr, class_id, result_class, x_int4, w_int8);
      end
      checks++;
      if ({busy1, done1, new_feat1, new_class1, frame_start1, result_class1} !== '0) begin
         errors++;
         $display("FAIL reset_outputs_edge busy=%b done=%b nf=%b nc=%b res=%h want all 0",
                  busy1, done1, new_feat1, new_class1, result_class1);
      end
      start = 1'b0; start1 = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_release busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_golden();
      int e0;
      int base;
      item_t o, e;
      load_mem(1'b0); clear_logs(); push_frame();
      base = score_log.size();
      @(negedge clk); start = 1'b1; e0 = cyc + 1;
      watch(1, 0); start = 1'b0;
      checks++;
      if (busy !== 1'b1 || feat_addr !== 2'd0 || w_addr !== 4'd0 || new_feat !== 1'b0) begin
         errors++;
         $display("FAIL golden_issue busy=%b fa=%h wa=%h nf=%b want 1 0 0 0", busy, feat_addr, w_addr, new_feat);
      end
      watch(40, 1); watch(3, 0);
      checks++;
      if (fs_cyc.size() != 1 || fs_cyc[0] != e0 + 1) begin
         errors++;
         $display("FAIL golden_first_feat count=%0d cyc=%0d want 1 at %0d", fs_cyc.size(), fs_cyc[0], e0 + 1);
      end
      checks++;
      if (obs_q.size() != 15 || last_nc_cyc != e0 + 15) begin
         errors++;
         $display("FAIL golden_contiguous items=%0d last_class_cyc=%0d want 15 at %0d", obs_q.size(), last_nc_cyc, e0 + 15);
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL golden_stream extra item %h", o); end
         else begin
            e = exp_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL golden_stream item got %h want %h", o, e); end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL golden_stream %0d items missing", exp_q.size()); exp_q.delete(); end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != e0 + 17 || busy_at_done) begin
         errors++;
         $display("FAIL golden_done count=%0d cyc=%0d busy_at_done=%b want 1 at %0d busy 0",
                  done_cyc.size(), done_cyc[0], busy_at_done, e0 + 17);
      end
      checks++;
      if (score_log.size() != base + 3 || score_log[base] != 260 || score_log[base + 1] != 61 || score_log[base + 2] != -396) begin
         errors++;
         $display("FAIL golden_scores got %0d %0d %0d want 260 61 -396",
                  score_log[base], score_log[base + 1], score_log[base + 2]);
      end
      checks++;
      if (result_class !== 3'd0) begin errors++; $display("FAIL golden_result got %0d want 0", result_class); end
      checks++;
      if (both_cnt != 0) begin errors++; $display("FAIL golden_overlap nf&nc high %0d cycles want 0", both_cnt); end
   endtask

   task automatic test_edge_sizes();
      logic [3:0] exp_v;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         exp_v = {k == 1, k == 2, k == 1, k == 4};
         checks++;
         if ({new_feat1, new_class1, frame_start1, done1} !== exp_v) begin
            errors++;
            $display("FAIL edge_stream cycle %0d nf/nc/fs/done=%b want %b", k, {new_feat1, new_class1, frame_start1, done1}, exp_v);
         end
         if (k == 1) begin
            checks++;
            if (x_int41 !== 4'hD || w_int81 !== 8'd9 || class_id1 !== 3'd0) begin
               errors++;
               $display("FAIL edge_data x=%h w=%h cid=%0d want d 09 0", x_int41, w_int81, class_id1);
            end
         end
      end
      checks++;
      if (result_class1 !== 3'd6 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL edge_result res=%0d busy=%b want 6 0", result_class1, busy1);
      end
   endtask

   task automatic test_busy_start();
      int e0;
      item_t o, e;
      load_mem(1'b0); clear_logs(); push_frame();
      @(negedge clk); start = 1'b1; e0 = cyc + 1;
      watch(1, 0); start = 1'b0;
      watch(6, 0);
      checks++;
      if (new_feat !== 1'b1 || class_id !== 3'd1) begin
         errors++;
         $display("FAIL busy_start_position nf=%b cid=%0d want 1 1", new_feat, class_id);
      end
      start = 1'b1; watch(1, 0); start = 1'b0;
      watch(40, 1); watch(4, 0);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL busy_start_stream extra item %h", o); end
         else begin
            e = exp_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL busy_start_stream item got %h want %h", o, e); end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL busy_start_stream %0d items missing", exp_q.size()); exp_q.delete(); end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != e0 + 17 || fs_cyc.size() != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_ignored dones=%0d cyc=%0d frames=%0d busy=%b want 1 at %0d 1 0",
                  done_cyc.size(), done_cyc[0], fs_cyc.size(), busy, e0 + 17);
      end
      checks++;
      if (result_class !== 3'd0) begin errors++; $display("FAIL busy_start_result got %0d want 0", result_class); end
   endtask

   task automatic test_back_to_back();
      int e0;
      item_t o, e;
      load_mem(1'b0); clear_logs(); push_frame(); push_frame();
      @(negedge clk); start = 1'b1; e0 = cyc + 1;
      watch(80, 2); start = 1'b0;
      watch(3, 0);
      checks++;
      if (done_cyc.size() != 2 || done_cyc[0] != e0 + 17 || done_cyc[1] != e0 + 35) begin
         errors++;
         $display("FAIL b2b_done count=%0d cyc=%0d,%0d want 2 at %0d,%0d",
                  done_cyc.size(), done_cyc[0], done_cyc[1], e0 + 17, e0 + 35);
      end
      checks++;
      if (fs_cyc.size() != 2 || fs_cyc[0] != e0 + 1 || fs_cyc[1] != done_cyc[0] + 2) begin
         errors++;
         $display("FAIL b2b_frame_start count=%0d cyc=%0d,%0d want 2 at %0d,%0d",
                  fs_cyc.size(), fs_cyc[0], fs_cyc[1], e0 + 1, done_cyc[0] + 2);
      end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_stream extra item %h", o); end
         else begin
            e = exp_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL b2b_stream item got %h want %h", o, e); end
         end
      end
      checks++;
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end missing=%0d busy=%b want 0 0", exp_q.size(), busy);
         exp_q.delete();
      end
   endtask

   task automatic test_swap();
      item_t o, e;
      load_mem(1'b1); clear_logs(); push_frame();
      @(negedge clk); start = 1'b1;
      watch(1, 0); start = 1'b0;
      watch(40, 1);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL swap_stream extra item %h", o); end
         else begin
            e = exp_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL swap_stream item got %h want %h", o, e); end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL swap_stream %0d items missing", exp_q.size()); exp_q.delete(); end
      checks++;
      if (addr_log.size() != NC * NF) begin
         errors++;
         $display("FAIL swap_waddr_count got %0d want %0d", addr_log.size(), NC * NF);
      end
      for (int i = 0; i < addr_log.size(); i++) begin
         checks++;
         if (addr_log[i] != i) begin errors++; $display("FAIL swap_waddr[%0d] got %0d want %0d", i, addr_log[i], i); end
      end
      checks++;
      if (done_cyc.size() != 1 || result_class !== 3'd1) begin
         errors++;
         $display("FAIL swap_result dones=%0d res=%0d want 1 1", done_cyc.size(), result_class);
      end
   endtask

   task automatic test_reset_mid();
      int e0;
      item_t o, e;
      clear_logs(); push_frame();
      @(negedge clk); start = 1'b1;
      watch(1, 0); start = 1'b0;
      watch(6, 0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, new_feat, new_class, frame_start, feat_addr, w_addr, class_id,
           result_class, x_int4, w_int8} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs busy=%b nf=%b nc=%b fa=%h wa=%h cid=%h res=%h x=%h w=%h want all 0",
                  busy, new_feat, new_class, feat_addr, w_addr, class_id, result_class, x_int4, w_int8);
      end
      watch(3, 0);
      checks++;
      if (done_cyc.size() != 0) begin errors++; $display("FAIL reset_mid_no_done got %0d dones want 0", done_cyc.size()); end
      exp_q.delete(); clear_logs();
      rst_n = 1'b1;
      push_frame();
      @(negedge clk); start = 1'b1; e0 = cyc + 1;
      watch(1, 0); start = 1'b0;
      watch(40, 1);
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front(); checks++;
         if (exp_q.size() == 0) begin errors++; $display("FAIL reset_mid_stream extra item %h", o); end
         else begin
            e = exp_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL reset_mid_stream item got %h want %h", o, e); end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL reset_mid_stream %0d items missing", exp_q.size()); exp_q.delete(); end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != e0 + 17 || result_class !== 3'd1) begin
         errors++;
         $display("FAIL reset_mid_refresh dones=%0d cyc=%0d res=%0d want 1 at %0d res 1",
                  done_cyc.size(), done_cyc[0], result_class, e0 + 17);
      end
   endtask

   initial begin
      load_mem(1'b0);
      test_reset();
      test_golden();
      test_edge_sizes();
      test_busy_start();
      test_back_to_back();
      test_swap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
